// File: rtl/dsp_post_adder_acc_if.sv
// Operand, control and result bundle for the DSP48A1 post-adder/accumulator.
// The driver (upstream pipeline) uses the master view; the post-adder uses slave.
interface dsp_post_adder_acc_if;
  logic        cep;
  logic        ceopmode;
  logic        cecarryin;
  logic [7:0]  opmode;
  logic [35:0] m;
  logic [47:0] c;
  logic [47:0] dab;
  logic [47:0] pcin;
  logic [47:0] p;
  logic [47:0] pcout;
  logic        carryout;
  logic        carryoutf;

  modport master (
    output cep, ceopmode, cecarryin, opmode, m, c, dab, pcin,
    input  p, pcout, carryout, carryoutf
  );

  modport slave (
    input  cep, ceopmode, cecarryin, opmode, m, c, dab, pcin,
    output p, pcout, carryout, carryoutf
  );
endinterface

// File: rtl/dsp_post_adder_acc.sv
// DSP48A1 post-adder/accumulator: X/Z operand muxes, 48-bit add/subtract with
// carry-in, optional P/carryout output registers and P feedback for MAC use.
module dsp_post_adder_acc #(
  parameter bit PREG        = 1'b1,
  parameter bit CARRYOUTREG = 1'b1,
  parameter bit OPMODEREG   = 1'b1,
  parameter bit CARRYINREG  = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  dsp_post_adder_acc_if.slave ops
);

  // Only the opmode bits that steer the datapath are kept:
  // {subtract, carry-in, z_sel[1:0], x_sel[1:0]}. Bits 4 and 6 are don't-care.
  logic [5:0]  opmode_in;
  logic [5:0]  opmode_q;
  logic [5:0]  op;
  logic        cin_q;
  logic        cin;
  logic        sub;
  logic [1:0]  x_sel;
  logic [1:0]  z_sel;
  logic [47:0] p_q;
  logic        carry_q;
  logic [47:0] p_fb;
  logic [47:0] x_val;
  logic [47:0] z_val;
  logic [48:0] x_ext;
  logic [48:0] z_ext;
  logic [48:0] cin_ext;
  logic [48:0] sum;
  logic [47:0] p_val;
  logic        carry_val;

  assign opmode_in = {ops.opmode[7], ops.opmode[5], ops.opmode[3:0]};

  // Opmode register, aligned with the upstream M/C pipeline stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      opmode_q <= '0;
    end else if (ops.ceopmode) begin
      opmode_q <= opmode_in;
    end
  end

  // Carry-in register, loaded straight from the opmode port's carry-in bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cin_q <= 1'b0;
    end else if (ops.cecarryin) begin
      cin_q <= ops.opmode[5];
    end
  end

  assign op    = OPMODEREG ? opmode_q : opmode_in;
  assign sub   = op[5];
  assign z_sel = op[3:2];
  assign x_sel = op[1:0];
  assign cin   = CARRYINREG ? cin_q : op[4];

  // Feedback always taps the P register; without it there is nothing to
  // feed back, and tapping the combinational result would form a loop.
  assign p_fb = PREG ? p_q : 48'd0;

  // X operand select.
  always_comb begin
    x_val = 48'd0;
    unique case (x_sel)
      2'b00: x_val = 48'd0;
      2'b01: x_val = {12'd0, ops.m};
      2'b10: x_val = p_fb;
      2'b11: x_val = ops.dab;
    endcase
  end

  // Z operand select.
  always_comb begin
    z_val = 48'd0;
    unique case (z_sel)
      2'b00: z_val = 48'd0;
      2'b01: z_val = ops.pcin;
      2'b10: z_val = p_fb;
      2'b11: z_val = ops.c;
    endcase
  end

  // 49-bit unsigned post-adder; bit 48 is carry on add, borrow on subtract.
  always_comb begin
    x_ext   = {1'b0, x_val};
    z_ext   = {1'b0, z_val};
    cin_ext = {48'd0, cin};
    if (sub) begin
      sum = z_ext - (x_ext + cin_ext);
    end else begin
      sum = z_ext + x_ext + cin_ext;
    end
  end

  // P output register; cep low freezes the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q <= 48'd0;
    end else if (ops.cep) begin
      p_q <= sum[47:0];
    end
  end

  // Carryout register, sharing the P clock enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else if (ops.cep) begin
      carry_q <= sum[48];
    end
  end

  assign p_val     = PREG ? p_q : sum[47:0];
  assign carry_val = CARRYOUTREG ? carry_q : sum[48];

  assign ops.p         = p_val;
  assign ops.pcout     = p_val;
  assign ops.carryout  = carry_val;
  assign ops.carryoutf = carry_val;

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Directed bench for dsp_post_adder_acc: a default build (all registers), an
// unregistered opmode/carry-in build and a fully combinational build.
module tb_dsp_post_adder_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dsp_post_adder_acc_if bus_d ();
  dsp_post_adder_acc_if bus_u ();
  dsp_post_adder_acc_if bus_c ();

  dsp_post_adder_acc dut_d (
    .clk (clk),
    .rst (rst),
    .ops (bus_d.slave)
  );

  dsp_post_adder_acc #(
    .OPMODEREG  (1'b0),
    .CARRYINREG (1'b0)
  ) dut_u (
    .clk (clk),
    .rst (rst),
    .ops (bus_u.slave)
  );

  dsp_post_adder_acc #(
    .PREG        (1'b0),
    .CARRYOUTREG (1'b0),
    .OPMODEREG   (1'b0),
    .CARRYINREG  (1'b0)
  ) dut_c (
    .clk (clk),
    .rst (rst),
    .ops (bus_c.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [47:0] DAB_V = 48'h0123_4567_89AB;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] opv, input logic [35:0] mv, input logic [47:0] cv,
                       input logic [47:0] dv, input logic [47:0] pv);
    bus_d.opmode = opv; bus_d.m = mv; bus_d.c = cv; bus_d.dab = dv; bus_d.pcin = pv;
    bus_u.opmode = opv; bus_u.m = mv; bus_u.c = cv; bus_u.dab = dv; bus_u.pcin = pv;
    bus_c.opmode = opv; bus_c.m = mv; bus_c.c = cv; bus_c.dab = dv; bus_c.pcin = pv;
  endtask

  task automatic en_all(input logic ep, input logic eo, input logic ec);
    bus_d.cep = ep; bus_d.ceopmode = eo; bus_d.cecarryin = ec;
    bus_u.cep = ep; bus_u.ceopmode = eo; bus_u.cecarryin = ec;
    bus_c.cep = ep; bus_c.ceopmode = eo; bus_c.cecarryin = ec;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with live operands on the default build
    en_all(1'b1, 1'b1, 1'b1);
    drive(8'h0D, 36'd5, 48'd9, 48'd0, 48'd0);
    rst = 1'b1;
    step();
    chk("rst_p_1", bus_d.p, 0);
    chk("rst_co_1", bus_d.carryout, 0);
    chk("rst_pcout_1", bus_d.pcout, 0);
    step();
    chk("rst_p_2", bus_d.p, 0);
    chk("rst_co_2", bus_d.carryout, 0);
    rst = 1'b0;
    step();
    chk("rel_p", bus_d.p, 0);
    chk("rel_pcout", bus_d.pcout, 0);
    chk("rel_u_p", bus_u.p, 14);
    step();
    chk("opreg_first", bus_d.p, 14);

    // add, with and without carry-in
    drive(8'h0D, 36'd5, 48'd10, 48'd0, 48'd0);
    step();
    chk("add_p", bus_u.p, 15);
    chk("add_co", bus_u.carryout, 0);
    drive(8'h2D, 36'd5, 48'd10, 48'd0, 48'd0);
    step();
    chk("add_cin_p", bus_u.p, 16);
    chk("add_cin_pcout", bus_u.pcout, 16);

    // accumulate m into P, hold, resume, lose on reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(8'h09, 36'd3, 48'd0, 48'd0, 48'd0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("acc", bus_u.p, 64'(3 * i));
    end
    bus_u.cep = 1'b0;
    step();
    chk("acc_hold_1", bus_u.p, 12);
    step();
    chk("acc_hold_2", bus_u.p, 12);
    bus_u.cep = 1'b1;
    step();
    chk("acc_resume", bus_u.p, 15);
    rst = 1'b1;
    step();
    chk("acc_rst", bus_u.p, 0);
    rst = 1'b0;
    step();
    chk("acc_after_rst", bus_u.p, 3);

    // subtract
    drive(8'h8D, 36'd3, 48'd10, 48'd0, 48'd0);
    step();
    chk("sub_p", bus_u.p, 7);
    chk("sub_co", bus_u.carryout, 0);
    drive(8'h8D, 36'd5, 48'd3, 48'd0, 48'd0);
    step();
    chk("sub_neg_p", bus_u.p, 48'hFFFF_FFFF_FFFE);
    chk("sub_neg_co", bus_u.carryout, 1);
    chk("sub_neg_cof", bus_u.carryoutf, 1);
    drive(8'hAD, 36'd3, 48'd10, 48'd0, 48'd0);
    step();
    chk("sub_cin_p", bus_u.p, 6);
    chk("sub_cin_co", bus_u.carryout, 0);

    // wrap-around and dab path
    drive(8'h0D, 36'd1, 48'd0, 48'd0, 48'd0);
    step();
    chk("wrap_load", bus_u.p, 1);
    drive(8'h0E, 36'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 48'd0);
    step();
    chk("wrap_p", bus_u.p, 0);
    chk("wrap_co", bus_u.carryout, 1);
    drive(8'h07, 36'd0, 48'd0, DAB_V, 48'd0);
    step();
    chk("dab_p", bus_u.p, DAB_V);
    chk("dab_co", bus_u.carryout, 0);
    drive(8'h0B, 36'd0, 48'd0, DAB_V, 48'd0);
    step();
    chk("dab_acc", bus_u.p, 48'h0246_8ACF_1356);

    // opmode register timing against the unregistered build
    en_all(1'b1, 1'b1, 1'b1);
    drive(8'h0D, 36'd5, 48'd10, 48'd0, 48'd100);
    step();
    step();
    chk("opr_base_d", bus_d.p, 15);
    chk("opr_base_u", bus_u.p, 15);
    drive(8'h05, 36'd5, 48'd10, 48'd0, 48'd100);
    step();
    chk("opr_sw_u", bus_u.p, 105);
    chk("opr_sw_d_old", bus_d.p, 15);
    step();
    chk("opr_sw_d_new", bus_d.p, 105);
    bus_d.ceopmode = 1'b0;
    drive(8'h0D, 36'd5, 48'd10, 48'd0, 48'd100);
    step();
    chk("opr_hold_d_1", bus_d.p, 105);
    chk("opr_hold_u", bus_u.p, 15);
    step();
    chk("opr_hold_d_2", bus_d.p, 105);

    // carry-in register enable
    bus_d.ceopmode  = 1'b1;
    bus_d.cecarryin = 1'b0;
    drive(8'h2D, 36'd5, 48'd10, 48'd0, 48'd100);
    step();
    step();
    chk("cinr_hold_d", bus_d.p, 15);
    chk("cinr_u", bus_u.p, 16);
    bus_d.cecarryin = 1'b1;
    step();
    step();
    chk("cinr_load_d", bus_d.p, 16);

    // fully combinational build: zero latency, feedback reads as 0
    drive(8'h0D, 36'd5, 48'd10, 48'd0, 48'd0);
    #1;
    chk("comb_add", bus_c.p, 15);
    chk("comb_pcout", bus_c.pcout, 15);
    drive(8'h09, 36'd3, 48'd0, 48'd0, 48'd0);
    #1;
    chk("comb_fb0", bus_c.p, 3);
    drive(8'h8D, 36'd5, 48'd3, 48'd0, 48'd0);
    #1;
    chk("comb_sub_p", bus_c.p, 48'hFFFF_FFFF_FFFE);
    chk("comb_sub_co", bus_c.carryout, 1);
    chk("comb_sub_cof", bus_c.carryoutf, 1);
    drive(8'h0E, 36'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 48'd0);
    #1;
    chk("comb_fb_c", bus_c.p, 48'hFFFF_FFFF_FFFF);
    chk("comb_fb_co", bus_c.carryout, 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
